// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - Arkanoid game-progress register stage: score, lives, serve delay, game over.
// Optional high-score register enabled by SCORE_KEEPER_HIGH_SCORE_EN.
module score_keeper #(
   parameter int LIVES_INIT  = 3,
   parameter int SERVE_TICKS = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tick,
   input  logic       start,
   input  logic       hit,
   input  logic [3:0] hit_points,
   input  logic       ball_lost,
   output logic [7:0] score,
   output logic [1:0] lives,
   output logic [7:0] high_score,
   output logic [1:0] state,
   output logic       ball_en,
   output logic       game_over
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      SERVE = 2'd2,
      OVER  = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] score_q, score_d;
   logic [1:0] lives_q, lives_d;
   logic [3:0] serve_cnt_q, serve_cnt_d;
   logic       ball_en_q, game_over_q;
   logic [8:0] sum;
   logic       enter_over;

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      lives_d     = lives_q;
      serve_cnt_d = serve_cnt_q;
      enter_over  = 1'b0;
      sum         = {1'b0, score_q} + {5'd0, hit_points};
      unique case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = PLAY;
               score_d = 8'd0;
               lives_d = 2'(LIVES_INIT);
            end
         end
         PLAY: begin
            if (hit)
               score_d = sum[8] ? 8'd255 : sum[7:0];
            // Loss is applied after the add so the high-score compare sees the final score.
            if (ball_lost) begin
               if (lives_q > 2'd1) begin
                  lives_d     = lives_q - 2'd1;
                  serve_cnt_d = 4'(SERVE_TICKS);
                  state_d     = SERVE;
               end else begin
                  lives_d    = 2'd0;
                  state_d    = OVER;
                  enter_over = 1'b1;
               end
            end
         end
         SERVE: begin
            if (tick) begin
               serve_cnt_d = serve_cnt_q - 4'd1;
               if (serve_cnt_q == 4'd1)
                  state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         score_q     <= 8'd0;
         lives_q     <= 2'd0;
         serve_cnt_q <= 4'd0;
         ball_en_q   <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         serve_cnt_q <= serve_cnt_d;
         ball_en_q   <= (state_d == PLAY);
         game_over_q <= (state_d == OVER);
      end
   end

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
   logic [7:0] high_score_q, high_score_d;

   always_comb begin
      high_score_d = high_score_q;
      if (enter_over && (score_d > high_score_q))
         high_score_d = score_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         high_score_q <= 8'd0;
      else
         high_score_q <= high_score_d;
   end

   assign high_score = high_score_q;
`else
   logic unused_enter_over;
   assign unused_enter_over = enter_over;
   assign high_score        = 8'd0;
`endif

   assign score     = score_q;
   assign lives     = lives_q;
   assign state     = state_q;
   assign ball_en   = ball_en_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper.
// Expected high_score follows SCORE_KEEPER_HIGH_SCORE_EN.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic       hit = 1'b0;
   logic [3:0] hit_points = 4'd0;
   logic       ball_lost = 1'b0;
   logic [7:0] score;
   logic [1:0] lives;
   logic [7:0] high_score;
   logic [1:0] state;
   logic       ball_en;
   logic       game_over;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   score_keeper #(.LIVES_INIT(3), .SERVE_TICKS(2)) dut (
      .clk(clk), .resetn(resetn), .tick(tick), .start(start), .hit(hit),
      .hit_points(hit_points), .ball_lost(ball_lost), .score(score), .lives(lives),
      .high_score(high_score), .state(state), .ball_en(ball_en), .game_over(game_over)
   );

   always #5 clk = ~clk;

   // Called at a negedge; inputs are sampled by the next posedge, returns at the following negedge.
   task automatic drive(input logic t, input logic s, input logic h, input logic [3:0] p,
                        input logic l);
      tick = t; start = s; hit = h; hit_points = p; ball_lost = l;
      @(negedge clk);
      tick = 1'b0; start = 1'b0; hit = 1'b0; hit_points = 4'd0; ball_lost = 1'b0;
   endtask

   task automatic lose_life();
      drive(0, 0, 0, 4'd0, 1);
      drive(1, 0, 0, 4'd0, 0);
      drive(1, 0, 0, 4'd0, 0);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d exp 0", state); end
      n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL reset_score got %0d exp 0", score); end
      n_cmp++; if (lives !== 2'd0) begin n_bad++; $display("FAIL reset_lives got %0d exp 0", lives); end
      n_cmp++; if (high_score !== 8'd0) begin n_bad++; $display("FAIL reset_high got %0d exp 0", high_score); end
      n_cmp++; if ({ball_en, game_over} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b exp 00", {ball_en, game_over}); end
      resetn = 1'b1;
      drive(1, 0, 1, 4'd9, 1);
      n_cmp++; if ({state, score} !== 10'd0) begin n_bad++; $display("FAIL idle_ignore got %0d/%0d exp 0/0", state, score); end
   endtask

   task automatic test_start();
      drive(0, 1, 0, 4'd0, 0);
      n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL start_state got %0d exp 1", state); end
      n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL start_lives got %0d exp 3", lives); end
      n_cmp++; if (score !== 8'd0) begin n_bad++; $display("FAIL start_score got %0d exp 0", score); end
      n_cmp++; if ({ball_en, game_over} !== 2'b10) begin n_bad++; $display("FAIL start_flags got %b exp 10", {ball_en, game_over}); end
   endtask

   task automatic test_back_to_back();
      drive(0, 0, 1, 4'd3, 0);
      drive(0, 1, 1, 4'd7, 0);
      n_cmp++; if (score !== 8'd10) begin n_bad++; $display("FAIL b2b_score got %0d exp 10", score); end
      n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL b2b_start_ignored got %0d exp 3", lives); end
   endtask

   task automatic test_serve();
      drive(1, 0, 0, 4'd0, 1);
      n_cmp++; if ({lives, state, ball_en} !== {2'd2, 2'd2, 1'b0}) begin n_bad++;
         $display("FAIL serve_enter got l%0d s%0d b%0d exp l2 s2 b0", lives, state, ball_en); end
      drive(1, 0, 0, 4'd0, 0);
      n_cmp++; if ({state, ball_en} !== {2'd2, 1'b0}) begin n_bad++; $display("FAIL serve_one_tick got s%0d b%0d exp s2 b0", state, ball_en); end
      drive(0, 1, 1, 4'd5, 1);
      n_cmp++; if ({score, lives, state} !== {8'd10, 2'd2, 2'd2}) begin n_bad++;
         $display("FAIL serve_ignore got sc%0d l%0d s%0d exp sc10 l2 s2", score, lives, state); end
      drive(1, 0, 0, 4'd0, 0);
      n_cmp++; if ({state, ball_en} !== {2'd1, 1'b1}) begin n_bad++; $display("FAIL serve_resume got s%0d b%0d exp s1 b1", state, ball_en); end
   endtask

   task automatic test_game_over();
      drive(0, 0, 1, 4'd15, 0);
      drive(0, 0, 1, 4'd15, 0);
      lose_life();
      n_cmp++; if ({score, lives, state} !== {8'd40, 2'd1, 2'd1}) begin n_bad++;
         $display("FAIL pre_over got sc%0d l%0d s%0d exp sc40 l1 s1", score, lives, state); end
      drive(0, 0, 1, 4'd5, 1);
      n_cmp++; if ({score, lives, state} !== {8'd45, 2'd0, 2'd3}) begin n_bad++;
         $display("FAIL over_enter got sc%0d l%0d s%0d exp sc45 l0 s3", score, lives, state); end
      n_cmp++; if ({ball_en, game_over} !== 2'b01) begin n_bad++; $display("FAIL over_flags got %b exp 01", {ball_en, game_over}); end
      n_cmp++; if (high_score !== (HS_EN ? 8'd45 : 8'd0)) begin n_bad++;
         $display("FAIL over_high got %0d exp %0d", high_score, HS_EN ? 45 : 0); end
      drive(1, 0, 1, 4'd8, 1);
      n_cmp++; if ({score, lives, state} !== {8'd45, 2'd0, 2'd3}) begin n_bad++;
         $display("FAIL over_hold got sc%0d l%0d s%0d exp sc45 l0 s3", score, lives, state); end
      // Second game ends at 30: lower score must not replace the high score.
      drive(0, 1, 0, 4'd0, 0);
      n_cmp++; if ({score, lives, state} !== {8'd0, 2'd3, 2'd1}) begin n_bad++;
         $display("FAIL restart got sc%0d l%0d s%0d exp sc0 l3 s1", score, lives, state); end
      drive(0, 0, 1, 4'd15, 0);
      drive(0, 0, 1, 4'd15, 0);
      lose_life();
      lose_life();
      drive(0, 0, 0, 4'd0, 1);
      n_cmp++; if ({score, state, high_score} !== {8'd30, 2'd3, (HS_EN ? 8'd45 : 8'd0)}) begin n_bad++;
         $display("FAIL over2 got sc%0d s%0d hs%0d exp sc30 s3 hs%0d", score, state, high_score, HS_EN ? 45 : 0); end
   endtask

   task automatic test_saturation();
      drive(0, 1, 0, 4'd0, 0);
      for (int i = 0; i < 16; i++) drive(0, 0, 1, 4'd15, 0);
      n_cmp++; if (score !== 8'd240) begin n_bad++; $display("FAIL sat_240 got %0d exp 240", score); end
      drive(0, 0, 1, 4'd15, 0);
      n_cmp++; if (score !== 8'd255) begin n_bad++; $display("FAIL sat_255 got %0d exp 255", score); end
      drive(0, 0, 1, 4'd4, 0);
      n_cmp++; if (score !== 8'd255) begin n_bad++; $display("FAIL sat_hold got %0d exp 255", score); end
      lose_life();
      lose_life();
      drive(0, 0, 0, 4'd0, 1);
      n_cmp++; if ({state, high_score} !== {2'd3, (HS_EN ? 8'd255 : 8'd0)}) begin n_bad++;
         $display("FAIL sat_high got s%0d hs%0d exp s3 hs%0d", state, high_score, HS_EN ? 255 : 0); end
   endtask

   task automatic test_mid_reset();
      drive(0, 1, 0, 4'd0, 0);
      drive(0, 0, 1, 4'd6, 0);
      drive(0, 0, 0, 4'd0, 1);
      n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mr_serve got %0d exp 2", state); end
      #2 resetn = 1'b0;
      #1;
      n_cmp++; if ({state, score, lives, high_score, ball_en, game_over} !== 22'd0) begin n_bad++;
         $display("FAIL mr_async got s%0d sc%0d l%0d hs%0d b%0d g%0d exp all 0",
                  state, score, lives, high_score, ball_en, game_over); end
      @(negedge clk);
      resetn = 1'b1;
      drive(1, 0, 1, 4'd3, 1);
      drive(1, 0, 0, 4'd0, 0);
      n_cmp++; if ({state, score, ball_en} !== 11'd0) begin n_bad++;
         $display("FAIL mr_idle got s%0d sc%0d b%0d exp 0", state, score, ball_en); end
      drive(0, 1, 0, 4'd0, 0);
      n_cmp++; if ({state, lives} !== {2'd1, 2'd3}) begin n_bad++; $display("FAIL mr_restart got s%0d l%0d exp s1 l3", state, lives); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_start();
      test_back_to_back();
      test_serve();
      test_game_over();
      test_saturation();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
